// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write FIFO: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Frames queued in the FIFO are sent back-to-back with no idle gap between them.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          data_in,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx,
    output logic                          done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = 4;

    localparam logic [PTR_W-1:0] PTR_STEP  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CLK_STEP  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CLK_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_STEP  = BIT_W'(1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [PTR_W:0]       count_next;
    logic [DATA_BITS-1:0] head;
    logic                 push, pop;

    // A full FIFO rejects the write even if a pop happens on the same edge.
    assign push = wr_en && !full;
    assign head = mem[rd_ptr];

    always_comb begin
        count_next = fifo_count;
        case ({push, pop})
            2'b10:   count_next = fifo_count + CNT_ONE;
            2'b01:   count_next = fifo_count - CNT_ONE;
            default: count_next = fifo_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            full       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (push) wr_ptr <= wr_ptr + PTR_STEP;
            if (pop)  rd_ptr <= rd_ptr + PTR_STEP;
            fifo_count <= count_next;
            full       <= (count_next == CNT_FULL);
            overflow   <= wr_en && full;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

    // ---------------- Transmit FSM ----------------
    state_t               state, state_next;
    logic [CNT_W-1:0]     clk_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 bit_end, frame_end, tx_next;

    assign busy    = (state != IDLE);
    assign bit_end = busy && (clk_cnt == CLK_LAST);

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        frame_end  = 1'b0;
        tx_next    = tx;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    state_next = START;
                    pop        = 1'b1;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    tx_next    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx != DATA_LAST) begin
                        tx_next = shift_q[1];
                    end else if (PARITY != 0) begin
                        state_next = PAR;
                        tx_next    = parity_q;
                    end else begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end && bit_idx == STOP_LAST) begin
                    frame_end = 1'b1;
                    // Chain straight into the next start bit when a word is waiting.
                    if (fifo_count != '0) begin
                        state_next = START;
                        pop        = 1'b1;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = IDLE;
                        tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            done     <= 1'b0;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
        end else begin
            state <= state_next;
            tx    <= tx_next;
            done  <= frame_end;
            // Every state change lands on a bit boundary, so clearing on bit_end restarts timing on entry.
            clk_cnt <= (busy && !bit_end) ? clk_cnt + CLK_STEP : '0;
            if (state_next != state) bit_idx <= '0;
            else if (bit_end)        bit_idx <= bit_idx + BIT_STEP;
            if (pop) begin
                shift_q  <= head;
                parity_q <= (PARITY == 2) ? ^head : ~^head;
            end else if (state == DATA && bit_end) begin
                shift_q <= shift_q >> 1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances in different frame formats, checked against
// expected line waveforms built from the frame rules with plain arithmetic.
module tb_uart_tx_fifo;

    localparam int NI = 4;
    localparam int CPB  [NI] = '{4, 4, 4, 2};
    localparam int DB   [NI] = '{8, 8, 8, 5};
    localparam int PAR  [NI] = '{0, 2, 1, 0};
    localparam int STOP [NI] = '{1, 2, 1, 1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NI-1:0] wr_en;
    logic [8:0]    din [NI];
    logic [NI-1:0] full_w, ovf_w, busy_w, tx_w, done_w;
    logic [2:0]    cnt_w [NI];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int done_cnt [NI] = '{0, 0, 0, 0};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NI; i++)
            if (done_w[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
    end

    uart_tx_fifo #(.CLKS_PER_BIT(CPB[0]), .DATA_BITS(DB[0]), .PARITY(PAR[0]), .STOP_BITS(STOP[0]), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .data_in(din[0][7:0]), .full(full_w[0]),
        .fifo_count(cnt_w[0]), .overflow(ovf_w[0]), .busy(busy_w[0]), .tx(tx_w[0]), .done(done_w[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB[1]), .DATA_BITS(DB[1]), .PARITY(PAR[1]), .STOP_BITS(STOP[1]), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .data_in(din[1][7:0]), .full(full_w[1]),
        .fifo_count(cnt_w[1]), .overflow(ovf_w[1]), .busy(busy_w[1]), .tx(tx_w[1]), .done(done_w[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB[2]), .DATA_BITS(DB[2]), .PARITY(PAR[2]), .STOP_BITS(STOP[2]), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[2]), .data_in(din[2][7:0]), .full(full_w[2]),
        .fifo_count(cnt_w[2]), .overflow(ovf_w[2]), .busy(busy_w[2]), .tx(tx_w[2]), .done(done_w[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB[3]), .DATA_BITS(DB[3]), .PARITY(PAR[3]), .STOP_BITS(STOP[3]), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en[3]), .data_in(din[3][4:0]), .full(full_w[3]),
        .fifo_count(cnt_w[3]), .overflow(ovf_w[3]), .busy(busy_w[3]), .tx(tx_w[3]), .done(done_w[3]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int frame_len(input int idx);
        return CPB[idx] * (1 + DB[idx] + ((PAR[idx] != 0) ? 1 : 0) + STOP[idx]);
    endfunction

    // Line level for every clock cycle of one frame, bit 0 = first start-bit cycle.
    function automatic logic [63:0] exp_wave(input int idx, input logic [8:0] word);
        int         lv [$];
        int         ones = 0;
        int         pos  = 0;
        logic [63:0] w   = '0;
        lv.push_back(0);
        for (int i = 0; i < DB[idx]; i++) begin
            lv.push_back(word[i] ? 1 : 0);
            ones += word[i] ? 1 : 0;
        end
        if (PAR[idx] == 2)      lv.push_back(ones % 2);
        else if (PAR[idx] == 1) lv.push_back(1 - ones % 2);
        for (int i = 0; i < STOP[idx]; i++) lv.push_back(1);
        foreach (lv[j])
            for (int k = 0; k < CPB[idx]; k++) begin
                w[pos] = (lv[j] != 0);
                pos++;
            end
        return w;
    endfunction

    task automatic write(input int idx, input logic [8:0] d);
        wr_en[idx] = 1'b1;
        din[idx]   = d;
        @(negedge clk);
        wr_en[idx] = 1'b0;
    endtask

    // Waits for the start bit, then records the line and busy for one whole frame.
    // Returns on the negedge of the frame's last cycle.
    task automatic capture(input int idx, input logic [8:0] word, input string tag, output int start);
        int          budget = 0;
        int          f      = frame_len(idx);
        logic [63:0] obs_tx = '0;
        logic [63:0] obs_bz = '0;
        logic [63:0] ones   = '0;
        start = cyc;
        do begin
            @(negedge clk);
            budget++;
        end while (tx_w[idx] !== 1'b0 && budget < 400);
        if (tx_w[idx] !== 1'b0) begin
            check({tag, "_start_timeout"}, 64'(tx_w[idx]), 64'd0);
            return;
        end
        start = cyc;
        for (int c = 0; c < f; c++) begin
            obs_tx[c] = tx_w[idx];
            obs_bz[c] = busy_w[idx];
            ones[c]   = 1'b1;
            if (c < f - 1) @(negedge clk);
        end
        check({tag, "_wave"}, obs_tx, exp_wave(idx, word));
        check({tag, "_busy"}, obs_bz, ones);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          s, s1, s2, d0;
        int          st [5];
        logic [8:0]  words [5] = '{9'h11, 9'h22, 9'h33, 9'h44, 9'h55};
        logic [8:0]  q [$];
        logic        seen_low;

        wr_en = '0;
        for (int i = 0; i < NI; i++) din[i] = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_tx",       64'(tx_w),     64'hF);
        check("rst_busy",     64'(busy_w),   64'h0);
        check("rst_done",     64'(done_w),   64'h0);
        check("rst_overflow", 64'(ovf_w),    64'h0);
        check("rst_full",     64'(full_w),   64'h0);
        check("rst_count",    64'(cnt_w[0]), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Default format, 0xA5: first-word latency, waveform, done at cycle 40
        write(0, 9'hA5);
        check("a5_count_after_write", 64'(cnt_w[0]), 64'd1);
        check("a5_tx_before_pop",     64'(tx_w[0]),  64'd1);
        capture(0, 9'hA5, "a5", s);
        @(negedge clk);
        check("a5_done_offset", 64'(cyc - s), 64'd40);
        check("a5_done_high",   64'(done_w[0]), 64'd1);
        check("a5_busy_low",    64'(busy_w[0]), 64'd0);
        @(negedge clk);
        check("a5_done_one_cycle", 64'(done_w[0]), 64'd0);

        // Parity and stop-bit variants
        write(1, 9'hA5);
        capture(1, 9'hA5, "even_a5_stop2", s);
        @(negedge clk);
        check("stop2_frame_len", 64'(cyc - s), 64'd48);
        check("stop2_done",      64'(done_w[1]), 64'd1);
        write(1, 9'h07);
        capture(1, 9'h07, "even_07", s);
        write(2, 9'hA5);
        capture(2, 9'hA5, "odd_a5", s);
        write(3, 9'h1F);
        capture(3, 9'h1F, "db5_1f", s);
        @(negedge clk);
        check("db5_frame_len", 64'(cyc - s), 64'd14);
        check("db5_done",      64'(done_w[3]), 64'd1);
        repeat (3) @(negedge clk);

        // FIFO fill, overflow and gap-free back-to-back frames
        d0 = done_cnt[0];
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    write(0, words[i]);
                    check($sformatf("fill_no_ovf_%0d", i), 64'(ovf_w[0]), 64'd0);
                end
                check("fill_full",  64'(full_w[0]), 64'd1);
                check("fill_count", 64'(cnt_w[0]),  64'd4);
                write(0, 9'h66);
                check("ovf_pulse",       64'(ovf_w[0]), 64'd1);
                check("ovf_count_held",  64'(cnt_w[0]), 64'd4);
                @(negedge clk);
                check("ovf_one_cycle",   64'(ovf_w[0]), 64'd0);
            end
            begin
                for (int i = 0; i < 5; i++) capture(0, words[i], $sformatf("b2b_%0d", i), st[i]);
            end
        join
        for (int i = 1; i < 5; i++)
            check($sformatf("b2b_spacing_%0d", i), 64'(st[i] - st[i-1]), 64'd40);
        @(negedge clk);
        check("b2b_last_done", 64'(done_w[0]), 64'd1);
        check("b2b_last_busy", 64'(busy_w[0]), 64'd0);
        repeat (3) @(negedge clk);
        check("b2b_done_pulses", 64'(done_cnt[0] - d0), 64'd5);
        check("b2b_count_empty", 64'(cnt_w[0]), 64'd0);
        check("b2b_tx_idle",     64'(tx_w[0]),  64'd1);

        // Write during the done pulse of the previous frame
        d0 = done_cnt[0];
        write(0, 9'hC3);
        capture(0, 9'hC3, "dw_first", s1);
        @(negedge clk);
        check("dw_done_high", 64'(done_w[0]), 64'd1);
        write(0, 9'h3C);
        capture(0, 9'h3C, "dw_second", s2);
        check("dw_start_offset", 64'(s2 - s1), 64'd42);
        repeat (4) @(negedge clk);
        check("dw_done_pulses", 64'(done_cnt[0] - d0), 64'd2);
        check("dw_count_empty", 64'(cnt_w[0]), 64'd0);

        // Asynchronous reset in the middle of a data bit with two words queued
        write(0, 9'h5A);
        write(0, 9'h66);
        write(0, 9'h77);
        repeat (13) @(negedge clk);
        check("mid_count_before_rst", 64'(cnt_w[0]), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx",    64'(tx_w[0]),   64'd1);
        check("mid_rst_busy",  64'(busy_w[0]), 64'd0);
        check("mid_rst_count", 64'(cnt_w[0]),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt[0];
        seen_low = 1'b0;
        repeat (120) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1) seen_low = 1'b1;
        end
        check("post_rst_line_idle", 64'(seen_low), 64'd0);
        check("post_rst_no_done",   64'(done_cnt[0] - d0), 64'd0);

        // Random words with random spacing against a queue model
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [8:0] w;
                    w = 9'($urandom_range(0, 255));
                    q.push_back(w);
                    write(0, w);
                    repeat ($urandom_range(30, 60)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [8:0] w;
                    wait (q.size() > 0);
                    w = q.pop_front();
                    capture(0, w, $sformatf("rnd_%0d_%02h", i, w), s);
                end
            end
        join
        repeat (3) @(negedge clk);
        check("rnd_count_empty", 64'(cnt_w[0]), 64'd0);
        check("rnd_tx_idle",     64'(tx_w[0]),  64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
